serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor computing d = a - b - bin, one bit per clock, LSB first.
//  Complements the combinational adder: a multi-cycle, low-area subtract path for the ALU.
//  Uses a start/done handshake.
//  Operands are captured on start. The result is published as one registered word
//  with a borrow-out.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; sampled only in IDLE or DONE
//  a         in   WIDTH  minuend; captured with start
//  b         in   WIDTH  subtrahend; captured with start
//  bin       in   1      borrow-in; captured with start
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse: d/bout/ovf updated this cycle
//  d         out  WIDTH  result, (a - b - bin) mod 2^WIDTH
//  bout      out  1      borrow-out: 1 iff a < b + bin (unsigned)
//  ovf       out  1      signed overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      state=IDLE; busy=0, done=0, d=0, bout=0, ovf=0.
//      Shift registers, borrow FF and bit counter cleared.
//      Any operation in flight is abandoned and no done is produced.
//  - FSM states: IDLE, SHIFT, DONE. All outputs are registered.
//  - IDLE, start=1: capture a, b into shift regs; borrow FF <= bin; cnt <= 0.
//    Go to SHIFT; busy=1 from the next cycle.
//  - IDLE, start=0: remain in IDLE.
//  - SHIFT, each edge, using x=a_sh[0], y=b_sh[0], c=borrow:
//      diff bit = x^y^c
//      borrow  <= (~x&y) | (~x&c) | (y&c)
//      diff bit shifted into result reg at MSB; a_sh, b_sh shift right; cnt++.
//  - SHIFT, edge with cnt==WIDTH-1:
//      d <= final result word; bout <= final borrow; ovf updated.
//      done <= 1; busy <= 0; go to DONE.
//  - Latency: start sampled at edge 0 -> done=1 and d valid after edge WIDTH.
//  - DONE lasts exactly one cycle.
//      start=1: accepted as in IDLE (back-to-back; throughput 1 op per WIDTH+1 cycles).
//      start=0: go to IDLE.
//      done is deasserted on the next edge either way.
//  - start while in SHIFT is ignored: not queued, operands not re-captured.
//  - d/bout/ovf change only on the completion edge.
//    Held stable between completions, including through SHIFT of the next op.
//  - Wrap-around: 0 - 0 - 1 gives d = all ones, bout = 1. No saturation.
//  - a, b and bin are don't-care except on the accepting edge.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//    ovf <= borrow into MSB XOR borrow out of MSB.
//    This is signed two's-complement overflow of a - b - bin.
//    Registered on the completion edge.
//  SERIAL_SUB_OVF_EN undefined:
//    ovf tied to 0; no extra flops. Port list is unchanged.
// TESTING (WIDTH=4)
//  1. a=5, b=3, bin=0, start pulse -> done after 4 edges; d=2, bout=0, busy high 4 cycles.
//  2. a=3, b=5, bin=0 -> d=14 (4'b1110), bout=1; ovf=0.
//  3. a=0, b=0, bin=1 -> d=15, bout=1 (wrap-around).
//     Then a=0, b=0, bin=0 -> d=0, bout=0.
//  4. a=4'b1000, b=1, bin=0 -> d=7, bout=0.
//     ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without.
//  5. Start a=9, b=4; pulse start again mid-SHIFT with a=1, b=1 -> single done; d=5.
//     Then back-to-back: start held in the DONE cycle with a=7, b=7 -> d=0 WIDTH edges later.
//  6. Deassert rst_n two edges into SHIFT:
//     all outputs 0 immediately (async), state IDLE, no done pulse.
//     After release, a=6, b=2 -> d=4.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The requester drives start and operands; the subtractor returns status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b - bin, LSB first, one bit per clock.
// Optional signed overflow flag is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;

    logic             x, y, c, diff, borrow_nxt;
    logic [WIDTH-1:0] word;

    assign x          = a_sh_q[0];
    assign y          = b_sh_q[0];
    assign c          = borrow_q;
    assign diff       = x ^ y ^ c;
    assign borrow_nxt = (~x & y) | (~x & c) | (y & c);
    // Completed-so-far result with the current difference bit placed at the MSB.
    assign word       = {diff, r_sh_q};

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.bin;
                    r_sh_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                r_sh_d   = word[WIDTH-1:1];
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    d_d     = word;
                    bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB differs from borrow out: signed overflow.
                    ovf_d   = borrow_q ^ borrow_nxt;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bout_q   <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operations
// checked against an integer-arithmetic reference model.
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [W-1:0] last_d;
    logic         last_bout;
    logic         last_ovf;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, both unsigned and signed views.
    task automatic model(input int a, input int b, input int bin,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int diff;
        int sa;
        int sb;
        int sd;
        diff = a - b - bin;
        ed   = diff[W-1:0];
        eb   = (diff < 0);
        sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd   = sa - sb - bin;
`ifdef SERIAL_SUB_OVF_EN
        eo   = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
`else
        eo   = 1'b0;
`endif
    endtask

    // Drive start for exactly one edge; returns at the negedge after the accepting edge.
    task automatic start_now(input int a, input int b, input int bin);
        bus.start = 1'b1;
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.bin   = bin[0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
    endtask

    task automatic start_op(input int a, input int b, input int bin);
        @(negedge clk);
        check("idle_done_low", 32'(bus.done), 32'd0);
        check("idle_busy_low", 32'(bus.busy), 32'd0);
        start_now(a, b, bin);
    endtask

    // Walk the fixed WIDTH-cycle latency; optionally pulse start mid-SHIFT with other operands.
    task automatic expect_result(input int a, input int b, input int bin, input bit poke);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        model(a, b, bin, ed, eb, eo);
        for (int k = 0; k < int'(W); k++) begin
            bus.start = 1'b0;
            check("shift_busy", 32'(bus.busy), 32'd1);
            check("shift_done", 32'(bus.done), 32'd0);
            check("shift_d_held", 32'(bus.d), 32'(last_d));
            check("shift_bout_held", 32'(bus.bout), 32'(last_bout));
            if (poke && k == 1) begin
                bus.start = 1'b1;
                bus.a     = W'(1);
                bus.b     = W'(1);
                bus.bin   = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("result_d", 32'(bus.d), 32'(ed));
        check("result_bout", 32'(bus.bout), 32'(eb));
        check("result_ovf", 32'(bus.ovf), 32'(eo));
        last_d    = ed;
        last_bout = eb;
        last_ovf  = eo;
    endtask

    task automatic do_op(input int a, input int b, input int bin);
        start_op(a, b, bin);
        expect_result(a, b, bin, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        last_d    = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(5, 3, 0);
        do_op(3, 5, 0);
        do_op(0, 0, 1);
        do_op(0, 0, 0);
        do_op(8, 1, 0);

        // Start ignored mid-SHIFT, then a back-to-back start in the DONE cycle.
        start_op(9, 4, 0);
        expect_result(9, 4, 0, 1'b1);
        start_now(7, 7, 0);
        expect_result(7, 7, 0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);

        // Asynchronous reset two edges into SHIFT.
        start_op(11, 2, 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_d", 32'(bus.d), 32'd0);
        check("arst_bout", 32'(bus.bout), 32'd0);
        check("arst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_d    = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(bus.done), 32'd0);
            check("post_rst_idle", 32'(bus.busy), 32'd0);
        end
        do_op(6, 2, 0);

        // Random operations, randomly chained back-to-back.
        for (int i = 0; i < 24; i++) begin
            int ra;
            int rb;
            int rc;
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            rc = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                start_now(ra, rb, rc);
            end else begin
                start_op(ra, rb, rc);
            end
            expect_result(ra, rb, rc, 1'b0);
        end
        @(negedge clk);
        check("final_done_low", 32'(bus.done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
